// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle for alu_op_sequencer.
//   req_*        : operation request, valid/ready handshake (requester -> sequencer)
//   rsp_*        : result and per-op error, valid/ready handshake (sequencer -> consumer)
//   sticky_error : accumulated error summary
//   busy         : sequencer is not idle
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_error;
  logic             sticky_error;
  logic             busy;

  // Requester/consumer side
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error, sticky_error, busy
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error, sticky_error, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation controller. Accepts one request at a time,
// finishes logic/add/sub/shift ops in the accepting cycle, and runs MUL
// (shift-add, LSB first) and DIV/MOD (restoring, MSB first) over WIDTH steps.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_op_sequencer_if.slave (request, response and status signals)
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_NOTA = 4'd1;
  localparam logic [3:0] OP_NOTB = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MOD  = 4'd12;
  localparam logic [3:0] OP_SHL  = 4'd13;
  localparam logic [3:0] OP_SHR  = 4'd14;
  localparam logic [3:0] OP_CLR  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [3:0]          op_q,     op_d;
  logic [WIDTH-1:0]    b_q,      b_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [PROD_W-1:0]   acc_q,    acc_d;
  logic [PROD_W-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                error_q,  error_d;
  logic                sticky_q, sticky_d;
  logic                rsp_valid_q, req_ready_q, busy_q;

  logic [PROD_W-1:0]   mul_sum;
  logic [WIDTH:0]      rem_sh;
  logic [WIDTH:0]      trial;
  logic [PROD_W-1:0]   div_next;
  logic [WIDTH:0]      single;

  // Single-cycle result: {error, result}
  function automatic logic [WIDTH:0] single_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    unique case (op)
      OP_AND:  r = {1'b0, a & b};
      OP_NOTA: r = {1'b0, ~a};
      OP_NOTB: r = {1'b0, ~b};
      OP_OR:   r = {1'b0, a | b};
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_NAND: r = {1'b0, ~(a & b)};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_XNOR: r = {1'b0, ~(a ^ b)};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      // Borrow lands in the top bit of the (WIDTH+1)-bit difference.
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_SHL:  r = {1'b0, a << b[3:0]};
      OP_SHR:  r = {1'b0, a >> b[3:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next-state, datapath step and output computation
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    error_d  = error_q;
    sticky_d = sticky_q;

    single   = single_op(bus.req_op, bus.req_a, bus.req_b);

    // Multiply step: acc accumulates the shifted multiplicand per multiplier bit.
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Divide step: acc = {remainder, dividend/quotient}; shift in next dividend bit.
    rem_sh   = {acc_q[PROD_W-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_q};
    div_next = {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                acc_q[WIDTH-2:0], ~trial[WIDTH]};

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          b_d   = bus.req_b;
          cnt_d = '0;
          if (bus.req_op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = PROD_W'(bus.req_a);
            mplier_d = bus.req_b;
            state_d  = S_ITER;
          end else if ((bus.req_op == OP_DIV) || (bus.req_op == OP_MOD)) begin
            if (bus.req_b == '0) begin
              result_d = '1;
              error_d  = 1'b1;
              state_d  = S_DONE;
            end else begin
              acc_d   = PROD_W'(bus.req_a);
              state_d = S_ITER;
            end
          end else begin
            result_d = single[WIDTH-1:0];
            error_d  = single[WIDTH];
            state_d  = S_DONE;
          end
        end
      end

      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = mul_sum[WIDTH-1:0];
            error_d  = |mul_sum[PROD_W-1:WIDTH];
            state_d  = S_DONE;
          end
        end else begin
          acc_d = div_next;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = (op_q == OP_DIV) ? div_next[WIDTH-1:0] : div_next[PROD_W-1:WIDTH];
            error_d  = 1'b0;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (bus.rsp_ready) begin
          sticky_d = (op_q == OP_CLR) ? 1'b0 : (sticky_q | error_q);
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; handshake/status flags registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
      sticky_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      error_q     <= error_d;
      sticky_q    <= sticky_d;
      rsp_valid_q <= (state_d == S_DONE);
      req_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_error    = error_q;
  assign bus.sticky_error = sticky_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vectors, backpressure,
// back-to-back throughput, reset abort and randomized ops against a reference model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic model_sticky;

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: {error, result} from plain integer arithmetic
  function automatic logic [16:0] ref_op(input logic [3:0] op, input int unsigned a,
                                         input int unsigned b);
    int unsigned r;
    bit          e;
    r = 0;
    e = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = ~a;
      4'd2:  r = ~b;
      4'd3:  r = a | b;
      4'd4:  r = ~(a | b);
      4'd5:  r = ~(a & b);
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a ^ b);
      4'd8:  begin r = a + b; e = (r > 65535); end
      4'd9:  begin r = a - b; e = (a < b); end
      4'd10: begin r = a * b; e = (r > 65535); end
      4'd11: if (b == 0) begin r = 65535; e = 1'b1; end else r = a / b;
      4'd12: if (b == 0) begin r = 65535; e = 1'b1; end else r = a % b;
      4'd13: r = a << (b % 16);
      4'd14: r = a >> (b % 16);
      default: r = 0;
    endcase
    return {e, 16'(r)};
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [15:0] b);
    if ((op == 4'd10) || (((op == 4'd11) || (op == 4'd12)) && (b != 16'd0))) return 17;
    return 1;
  endfunction

  // Issue one request from idle, wait for the response, stall, then consume it.
  // Called #1 after a rising edge with rsp_ready low.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, output int lat, output logic [15:0] res,
                        output logic err, output logic sticky);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = 16'($urandom);
    bus.req_b     = 16'($urandom);
    bus.req_op    = 4'($urandom);
    lat = 1;
    while (!bus.rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.rsp_result;
    err = bus.rsp_error;
    repeat (stall) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    sticky = bus.sticky_error;
  endtask

  task automatic test_reset();
    int          lat;
    logic [15:0] res;
    logic        err, stk;
    bit          seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b need 1", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b need 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_result !== 16'd0) $display("FAIL reset_result: got %0h need 0", bus.rsp_result); else n_pass++;
    n_checks++; if (bus.rsp_error !== 1'b0) $display("FAIL reset_error: got %b need 0", bus.rsp_error); else n_pass++;
    n_checks++; if (bus.sticky_error !== 1'b0) $display("FAIL reset_sticky: got %b need 0", bus.sticky_error); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", bus.busy); else n_pass++;

    // Set sticky, then abort a MUL mid-iteration
    run_op(4'd10, 16'd40000, 16'd2, 0, lat, res, err, stk);
    n_checks++; if (stk !== 1'b1) $display("FAIL pre_abort_sticky: got %b need 1", stk); else n_pass++;
    bus.req_op = 4'd10; bus.req_a = 16'd7; bus.req_b = 16'd9; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_mid: got %b need 1", bus.busy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid: got %b need 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b need 0", bus.busy); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL abort_req_ready: got %b need 1", bus.req_ready); else n_pass++;
    n_checks++; if (bus.sticky_error !== 1'b0) $display("FAIL abort_sticky: got %b need 0", bus.sticky_error); else n_pass++;
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_response: got %b need 0", seen); else n_pass++;
    model_sticky = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  d_op  [9] = '{4'd11, 4'd12, 4'd10, 4'd10, 4'd11, 4'd15, 4'd8, 4'd9, 4'd13};
    int unsigned d_a   [9] = '{40000, 21193, 40000, 300, 5, 0, 40000, 3, 1};
    int unsigned d_b   [9] = '{50001, 3390, 2, 200, 0, 0, 30000, 5, 19};
    int unsigned d_res [9] = '{0, 853, 14464, 60000, 65535, 0, 4464, 65534, 8};
    logic        d_err [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int          d_lat [9] = '{17, 17, 17, 17, 1, 1, 1, 1, 1};
    logic        d_stk [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int          lat;
    logic [15:0] res;
    logic        err, stk;
    for (int i = 0; i < 9; i++) begin
      run_op(d_op[i], 16'(d_a[i]), 16'(d_b[i]), 0, lat, res, err, stk);
      n_checks++; if (res !== 16'(d_res[i])) $display("FAIL dir%0d_result: got %0d need %0d", i, res, d_res[i]); else n_pass++;
      n_checks++; if (err !== d_err[i]) $display("FAIL dir%0d_error: got %b need %b", i, err, d_err[i]); else n_pass++;
      n_checks++; if (lat !== d_lat[i]) $display("FAIL dir%0d_latency: got %0d need %0d", i, lat, d_lat[i]); else n_pass++;
      n_checks++; if (stk !== d_stk[i]) $display("FAIL dir%0d_sticky: got %b need %b", i, stk, d_stk[i]); else n_pass++;
    end
    model_sticky = d_stk[8];
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    bus.req_op = 4'd6; bus.req_a = 16'hF0F0; bus.req_b = 16'h0FF0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    // Second request presented immediately and held through the stall
    bus.req_op = 4'd8; bus.req_a = 16'd1; bus.req_b = 16'd2; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'hFF00)
        $display("FAIL bp_hold%0d: got valid=%b result=%0h need valid=1 result=ff00", i, bus.rsp_valid, bus.rsp_result);
      else n_pass++;
      n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready%0d: got %b need 0", i, bus.req_ready); else n_pass++;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL bp_not_accepted_at_handshake: got valid=%b busy=%b need 0/0", bus.rsp_valid, bus.busy);
    else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp = ref_op(4'd8, 1, 2);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp[15:0])
      $display("FAIL bp_second_req: got valid=%b result=%0d need valid=1 result=%0d", bus.rsp_valid, bus.rsp_result, exp[15:0]);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    model_sticky = model_sticky | exp[16];
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [16:0] exp;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      exp = ref_op(4'd8, a, b);
      bus.req_op = 4'd8; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp[15:0] || bus.rsp_error !== exp[16])
        $display("FAIL b2b%0d: got valid=%b result=%0d err=%b need 1/%0d/%b", i, bus.rsp_valid, bus.rsp_result, bus.rsp_error, exp[15:0], exp[16]);
      else n_pass++;
      @(posedge clk); #1;
      model_sticky = model_sticky | exp[16];
      n_checks++; if (bus.req_ready !== 1'b1 || bus.sticky_error !== model_sticky)
        $display("FAIL b2b%0d_idle: got ready=%b sticky=%b need 1/%b", i, bus.req_ready, bus.sticky_error, model_sticky);
      else n_pass++;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] a, b, res;
    logic [16:0] exp;
    logic        err, stk;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 24));
      exp = ref_op(op, a, b);
      run_op(op, a, b, int'($urandom_range(0, 3)), lat, res, err, stk);
      model_sticky = (op == 4'd15) ? 1'b0 : (model_sticky | exp[16]);
      n_checks++; if (res !== exp[15:0]) $display("FAIL rnd%0d_result op=%0d a=%0d b=%0d: got %0d need %0d", i, op, a, b, res, exp[15:0]); else n_pass++;
      n_checks++; if (err !== exp[16]) $display("FAIL rnd%0d_error op=%0d: got %b need %b", i, op, err, exp[16]); else n_pass++;
      n_checks++; if (lat !== ref_lat(op, b)) $display("FAIL rnd%0d_latency op=%0d: got %0d need %0d", i, op, lat, ref_lat(op, b)); else n_pass++;
      n_checks++; if (stk !== model_sticky) $display("FAIL rnd%0d_sticky: got %b need %b", i, stk, model_sticky); else n_pass++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 16'd0;
    bus.req_b     = 16'd0;
    bus.rsp_ready = 1'b0;
    model_sticky  = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
